rgb2ycbcr_block_stream: RTL and testbench



---
 rtl/rgb2ycbcr_block_stream.sv | 175 +++++++++++++++++
 tb/tb_rgb2ycbcr_block_stream.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2ycbcr_block_stream.sv
// Block RGB->YCbCr converter: latches a PIXELS-pixel block, converts LANES pixels per beat
// through a 2-stage pipeline, presents the whole block with valid/ready. Define RGB2YCC_LEVEL_SHIFT_EN for signed level-shifted output.
module rgb2ycbcr_block_stream #(
  parameter int FP_WIDTH = 32,
  parameter int PIXELS   = 64,
  parameter int LANES    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [8*PIXELS-1:0]          r_all,
  input  logic [8*PIXELS-1:0]          g_all,
  input  logic [8*PIXELS-1:0]          b_all,
  output logic [FP_WIDTH*PIXELS-1:0]   y_all,
  output logic [FP_WIDTH*PIXELS-1:0]   cb_all,
  output logic [FP_WIDTH*PIXELS-1:0]   cr_all,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         done,
  output logic                         busy
);

  localparam int BEATS = PIXELS / LANES;
  localparam int BW    = $clog2(BEATS + 1);

  if (PIXELS % LANES != 0) begin : g_bad_lanes
    $error("PIXELS must be a multiple of LANES");
  end
  if (FP_WIDTH < 25) begin : g_bad_width
    $error("FP_WIDTH must be at least 25");
  end

  localparam logic [16:0] K_YR  = 17'd19595;
  localparam logic [16:0] K_YG  = 17'd38470;
  localparam logic [16:0] K_YB  = 17'd7471;
  localparam logic [16:0] K_CBR = 17'd11059;
  localparam logic [16:0] K_CBG = 17'd21709;
  localparam logic [16:0] K_CBB = 17'd32768;
  localparam logic [16:0] K_CRR = 17'd32768;
  localparam logic [16:0] K_CRG = 17'd27439;
  localparam logic [16:0] K_CRB = 17'd5329;

`ifdef RGB2YCC_LEVEL_SHIFT_EN
  localparam logic [23:0] Y_OFS = 24'h800000;
  localparam logic [23:0] C_OFS = 24'h000000;
`else
  localparam logic [23:0] Y_OFS = 24'h000000;
  localparam logic [23:0] C_OFS = 24'h800000;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     beat;
  logic              drain_cnt;
  logic [8*PIXELS-1:0] r_buf, g_buf, b_buf;
  logic              issue;

  logic              s1_valid;
  logic [BW-1:0]     s1_beat;
  logic [23:0]       prod [LANES][9];
  logic [23:0]       y_sum  [LANES];
  logic [23:0]       cb_sum [LANES];
  logic [23:0]       cr_sum [LANES];

  // Every product fits in 24 bits (255 * 38470 < 2^24), so the multiply is lossless.
  function automatic logic [23:0] mul(input logic [7:0] px, input logic [16:0] coef);
    return 24'(px) * 24'(coef);
  endfunction

  function automatic logic [FP_WIDTH-1:0] extend(input logic [23:0] v);
`ifdef RGB2YCC_LEVEL_SHIFT_EN
    return {{(FP_WIDTH-24){v[23]}}, v};
`else
    return {{(FP_WIDTH-24){1'b0}}, v};
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid)            state_nxt = RUN;
      RUN:   if (beat == BW'(BEATS))  state_nxt = DRAIN;
      DRAIN: if (drain_cnt)           state_nxt = OUT;
      OUT:   if (out_ready)           state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
    issue     = (state == RUN) && (beat != BW'(BEATS));
  end

  // The beat counter runs one past the last beat so the final issue has left RUN before DRAIN starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat      <= '0;
      drain_cnt <= 1'b0;
      done      <= 1'b0;
      r_buf     <= '0;
      g_buf     <= '0;
      b_buf     <= '0;
    end else begin
      done      <= (state == DRAIN) && drain_cnt;
      drain_cnt <= (state == DRAIN) ? !drain_cnt : 1'b0;
      if (state == IDLE && in_valid) begin
        r_buf <= r_all;
        g_buf <= g_all;
        b_buf <= b_all;
        beat  <= '0;
      end else if (issue) begin
        beat  <= beat + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_beat  <= '0;
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < 9; k++)
          prod[l][k] <= '0;
    end else begin
      s1_valid <= issue;
      s1_beat  <= beat;
      if (issue) begin
        for (int l = 0; l < LANES; l++) begin
          prod[l][0] <= mul(r_buf[(int'(beat)*LANES + l)*8 +: 8], K_YR);
          prod[l][1] <= mul(g_buf[(int'(beat)*LANES + l)*8 +: 8], K_YG);
          prod[l][2] <= mul(b_buf[(int'(beat)*LANES + l)*8 +: 8], K_YB);
          prod[l][3] <= mul(r_buf[(int'(beat)*LANES + l)*8 +: 8], K_CBR);
          prod[l][4] <= mul(g_buf[(int'(beat)*LANES + l)*8 +: 8], K_CBG);
          prod[l][5] <= mul(b_buf[(int'(beat)*LANES + l)*8 +: 8], K_CBB);
          prod[l][6] <= mul(r_buf[(int'(beat)*LANES + l)*8 +: 8], K_CRR);
          prod[l][7] <= mul(g_buf[(int'(beat)*LANES + l)*8 +: 8], K_CRG);
          prod[l][8] <= mul(b_buf[(int'(beat)*LANES + l)*8 +: 8], K_CRB);
        end
      end
    end
  end

  // Sums are taken modulo 2^24; every true result fits there, unsigned or signed.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      y_sum[l]  = prod[l][0] + prod[l][1] + prod[l][2] - Y_OFS;
      cb_sum[l] = C_OFS - prod[l][3] - prod[l][4] + prod[l][5];
      cr_sum[l] = C_OFS + prod[l][6] - prod[l][7] - prod[l][8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_all  <= '0;
      cb_all <= '0;
      cr_all <= '0;
    end else if (s1_valid) begin
      for (int l = 0; l < LANES; l++) begin
        y_all [(int'(s1_beat)*LANES + l)*FP_WIDTH +: FP_WIDTH] <= extend(y_sum[l]);
        cb_all[(int'(s1_beat)*LANES + l)*FP_WIDTH +: FP_WIDTH] <= extend(cb_sum[l]);
        cr_all[(int'(s1_beat)*LANES + l)*FP_WIDTH +: FP_WIDTH] <= extend(cr_sum[l]);
      end
    end
  end

endmodule

// File: tb/tb_rgb2ycbcr_block_stream.sv
// Scoreboard bench for rgb2ycbcr_block_stream: driver pushes model blocks, monitor pops on accept
// and checks results, latency, handshake and reset behaviour.
module tb_rgb2ycbcr_block_stream;

  localparam int FP_WIDTH = 32;
  localparam int PIXELS   = 64;
  localparam int LANES    = 8;
  localparam int BEATS    = PIXELS / LANES;
  localparam int LAT      = BEATS + 3;
  localparam int PW       = 8 * PIXELS;
  localparam int OW       = FP_WIDTH * PIXELS;

  typedef struct {
    logic [OW-1:0] y;
    logic [OW-1:0] cb;
    logic [OW-1:0] cr;
  } blk_t;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready, done, busy;
  logic [PW-1:0] r_all, g_all, b_all;
  logic [OW-1:0] y_all, cb_all, cr_all;

  blk_t exp_q[$];
  blk_t cur;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic rst_applied = 1'b1;
  bit   inflight = 0;
  bit   out_seen = 0;
  bit   timeout_flagged = 0;
  int   accept_cyc = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;
  int   n_out = 0;

  always #5 clk = ~clk;

  rgb2ycbcr_block_stream #(.FP_WIDTH(FP_WIDTH), .PIXELS(PIXELS), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .r_all(r_all), .g_all(g_all), .b_all(b_all),
    .y_all(y_all), .cb_all(cb_all), .cr_all(cr_all),
    .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .busy(busy)
  );

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_applied <= !rst_n;
  end

  // Reference conversion straight from the coefficient table, one pixel at a time.
  function automatic blk_t model(input logic [PW-1:0] r, input logic [PW-1:0] g, input logic [PW-1:0] b);
    blk_t m;
    int rr, gg, bb, y, cb, cr;
    for (int i = 0; i < PIXELS; i++) begin
      rr = r[i*8 +: 8];
      gg = g[i*8 +: 8];
      bb = b[i*8 +: 8];
      y  = 19595*rr + 38470*gg + 7471*bb;
      cb = 8388608 - 11059*rr - 21709*gg + 32768*bb;
      cr = 8388608 + 32768*rr - 27439*gg - 5329*bb;
`ifdef RGB2YCC_LEVEL_SHIFT_EN
      y  = y - 8388608;
      cb = cb - 8388608;
      cr = cr - 8388608;
`endif
      m.y [i*FP_WIDTH +: FP_WIDTH] = y;
      m.cb[i*FP_WIDTH +: FP_WIDTH] = cb;
      m.cr[i*FP_WIDTH +: FP_WIDTH] = cr;
    end
    return m;
  endfunction

  function automatic logic [PW-1:0] fill(input logic [7:0] v);
    logic [PW-1:0] f;
    for (int i = 0; i < PIXELS; i++) f[i*8 +: 8] = v;
    return f;
  endfunction

  function automatic logic [PW-1:0] rand_pix();
    logic [PW-1:0] f;
    for (int i = 0; i < PW/32; i++) f[i*32 +: 32] = $urandom();
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic checkBlock(input string name, input logic [OW-1:0] actual, input logic [OW-1:0] expected);
    int idx;
    checks++;
    if (actual !== expected) begin
      failures++;
      idx = 0;
      for (int i = PIXELS-1; i >= 0; i--)
        if (actual[i*FP_WIDTH +: FP_WIDTH] !== expected[i*FP_WIDTH +: FP_WIDTH]) idx = i;
      $display("[TB] FAIL %s pixel %0d actual=0x%0h expected=0x%0h at cycle %0d", name, idx,
               actual[idx*FP_WIDTH +: FP_WIDTH], expected[idx*FP_WIDTH +: FP_WIDTH], cyc);
    end
  endtask

  // Monitor: samples on the falling edge and owns the accept/complete bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_applied) begin
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_busy", busy, 0);
        checkBlock("reset_y", y_all, '0);
        checkBlock("reset_cb", cb_all, '0);
        checkBlock("reset_cr", cr_all, '0);
        inflight = 0;
        out_seen = 0;
        timeout_flagged = 0;
      end else begin
        checkOutput("in_ready", in_ready, inflight ? 0 : 1);
        checkOutput("busy", busy, inflight ? 1 : 0);
        if (out_valid) begin
          if (!inflight) begin
            checkOutput("unexpected_out_valid", out_valid, 0);
          end else if (!out_seen) begin
            checkOutput("latency", cyc - accept_cyc, LAT);
            checkOutput("done_first", done, 1);
            checkBlock("y", y_all, cur.y);
            checkBlock("cb", cb_all, cur.cb);
            checkBlock("cr", cr_all, cur.cr);
            out_seen = 1;
          end else begin
            checkOutput("done_once", done, 0);
            checkBlock("y_stable", y_all, cur.y);
            checkBlock("cb_stable", cb_all, cur.cb);
            checkBlock("cr_stable", cr_all, cur.cr);
          end
          if (out_ready) begin
            inflight = 0;
            out_seen = 0;
            out_cnt++;
          end
        end else begin
          checkOutput("done_idle", done, 0);
          if (inflight && !timeout_flagged && (cyc - accept_cyc > LAT)) begin
            checkOutput("latency_timeout", cyc - accept_cyc, LAT);
            timeout_flagged = 1;
          end
        end
        if (in_valid && in_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("expected_queue", 0, 1);
          end else begin
            cur = exp_q.pop_front();
            inflight = 1;
            timeout_flagged = 0;
            accept_cyc = cyc + 1;
            acc_cnt++;
          end
        end
      end
    end
  end

  task automatic issueBlock(input logic [PW-1:0] r, input logic [PW-1:0] g, input logic [PW-1:0] b);
    exp_q.push_back(model(r, g, b));
    r_all = r;
    g_all = g;
    b_all = b;
    in_valid = 1'b1;
  endtask

  task automatic waitAccept();
    int start, n;
    start = acc_cnt;
    n = 0;
    while (acc_cnt == start && n < 200) begin
      @(posedge clk);
      n++;
    end
    checkOutput("accepted", acc_cnt - start, 1);
    #1 in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [PW-1:0] r, input logic [PW-1:0] g, input logic [PW-1:0] b);
    issueBlock(r, g, b);
    waitAccept();
  endtask

  task automatic waitOut(input int target);
    int n;
    n = 0;
    while (out_cnt < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    checkOutput("out_count", out_cnt, target);
    #1;
  endtask

  initial begin
    logic [PW-1:0] ra, ga, ba;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    r_all = '0; g_all = '0; b_all = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(fill(8'd0), fill(8'd0), fill(8'd0));       waitOut(++n_out);
    applyStimulus(fill(8'd255), fill(8'd0), fill(8'd0));     waitOut(++n_out);
    applyStimulus(fill(8'd255), fill(8'd255), fill(8'd255)); waitOut(++n_out);
    for (int i = 0; i < PIXELS; i++) begin
      ra[i*8 +: 8] = 8'(i);
      ga[i*8 +: 8] = 8'(2*i);
      ba[i*8 +: 8] = 8'(3*i);
    end
    applyStimulus(ra, ga, ba); waitOut(++n_out);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(rand_pix(), rand_pix(), rand_pix());
      waitOut(++n_out);
    end

    $display("[TB] back-to-back blocks");
    for (int k = 0; k < 3; k++) applyStimulus(rand_pix(), rand_pix(), rand_pix());
    n_out += 3;
    waitOut(n_out);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(rand_pix(), rand_pix(), rand_pix());
    issueBlock(rand_pix(), rand_pix(), rand_pix());
    repeat (LAT + 20) @(posedge clk);
    #1 out_ready = 1'b1;
    waitAccept();
    n_out += 2;
    waitOut(n_out);

    $display("[TB] reset mid-block");
    applyStimulus(rand_pix(), rand_pix(), rand_pix());
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(rand_pix(), rand_pix(), rand_pix());
    waitOut(++n_out);

    repeat (3) @(posedge clk);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
